pwm_compare: RTL and testbench

PWM_COMPARE -- requirements
Module: pwm_compare

---
 rtl/pwm_pkg.sv | 8 +
 rtl/pwm_compare_if.sv | 12 +
 rtl/pwm_deadtime.sv | 36 +++
 rtl/pwm_compare.sv | 82 ++++++++
 tb/tb_pwm_compare.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state type and sizing constants for pwm_compare.
//   DUTY_W       : width of count, duty values and the compare
//   DEADTIME_DEF : default dead-time length in clk cycles
package pwm_pkg;
  localparam int DUTY_W = 8;
  localparam int DEADTIME_DEF = 4;
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
endpackage

// File: rtl/pwm_compare_if.sv
// pwm_compare_if: valid/ready channel carrying new duty values.
//   duty_data  : new duty value (master -> slave)
//   duty_valid : duty_data valid (master -> slave)
//   duty_ready : slave can accept a value (slave -> master)
interface pwm_compare_if;
  import pwm_pkg::*;
  logic [DUTY_W-1:0] duty_data;
  logic duty_valid;
  logic duty_ready;
  modport master (output duty_data, duty_valid, input duty_ready);
  modport slave (input duty_data, duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: dead-time insertion for the complementary output pair.
//   clk, rst_n : clock and active-low reset (already synchronised)
//   act        : compare is running; pwm_n only drives while running
//   raw        : unregistered compare result (count < duty)
//   pwm, pwm_n : registered outputs, each delayed on its rising edge
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DEADTIME = DEADTIME_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic act,
  input  logic raw,
  output logic pwm,
  output logic pwm_n
);
  localparam logic [3:0] DT = 4'(DEADTIME);
  logic raw_n;
  logic [3:0] cnt_h, cnt_l;
  assign raw_n = act & ~raw;
  // cnt_* hold how many preceding cycles the level has been held (saturating);
  // an output only rises once that reaches DT, and drops with its level.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_h <= '0;
      cnt_l <= '0;
      pwm <= 1'b0;
      pwm_n <= 1'b0;
    end else begin
      cnt_h <= !raw ? '0 : (cnt_h == DT) ? cnt_h : cnt_h + 4'd1;
      cnt_l <= !raw_n ? '0 : (cnt_l == DT) ? cnt_l : cnt_l + 4'd1;
      pwm <= raw & (cnt_h == DT);
      pwm_n <= raw_n & (cnt_l == DT);
    end
endmodule

// File: rtl/pwm_compare.sv
// pwm_compare: compare-based PWM with shadowed duty update at period boundaries.
//   clk          : clock
//   rst          : asynchronous active-low reset, released synchronously
//   en           : output enable (level)
//   count        : upstream free-running counter value
//   tcount       : upstream terminal-count pulse (period boundary)
//   duty         : slave side of the duty valid/ready channel
//   pwm          : registered PWM output
//   pwm_n        : complementary output, only when PWM_COMPL_EN is defined
//   period_done  : one-cycle pulse per completed period while running
// Build option PWM_COMPL_EN adds pwm_n with DEADTIME-cycle dead-time insertion.
module pwm_compare
  import pwm_pkg::*;
#(
  parameter int DEADTIME = DEADTIME_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DUTY_W-1:0] count,
  input  logic              tcount,
  pwm_compare_if.slave      duty,
  output logic              pwm,
`ifdef PWM_COMPL_EN
  output logic              pwm_n,
`endif
  output logic              period_done
);
  if (DEADTIME < 1 || DEADTIME > 15) begin : g_bad_deadtime
    $error("pwm_compare: DEADTIME must be 1..15");
  end
  logic [1:0] rst_q;
  logic rst_s, run, raw_d, load, xfer, pending;
  logic [DUTY_W-1:0] duty_active, shadow;
  state_t state, state_nx;
  // Reset asserts asynchronously through rst_q and releases two edges later.
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_q <= 2'b00;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_s = rst_q[1];
  always_comb begin
    state_nx = !en ? IDLE
             : (state == IDLE) ? ARMED
             : (state == ARMED && tcount) ? RUN
             : state;
    run = (state == RUN) && en;
    raw_d = run && (count < duty_active);
    // A value can only be pending if it was accepted before this boundary,
    // so a transfer on the tcount cycle waits for the following boundary.
    load = tcount && pending && (state != IDLE);
    xfer = duty.duty_valid && duty.duty_ready;
  end
  assign duty.duty_ready = ~pending;
  always_ff @(posedge clk or negedge rst_s)
    if (!rst_s) begin
      state <= IDLE;
      duty_active <= '0;
      shadow <= '0;
      pending <= 1'b0;
      period_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (xfer) shadow <= duty.duty_data;
      if (load) duty_active <= shadow;
      pending <= xfer | (pending & ~load);
      period_done <= run & tcount;
    end
`ifdef PWM_COMPL_EN
  pwm_deadtime #(.DEADTIME(DEADTIME)) u_deadtime (
    .clk   (clk),
    .rst_n (rst_s),
    .act   (run),
    .raw   (raw_d),
    .pwm   (pwm),
    .pwm_n (pwm_n)
  );
`else
  always_ff @(posedge clk or negedge rst_s)
    if (!rst_s) pwm <= 1'b0;
    else pwm <= raw_d;
`endif
endmodule

// File: tb/tb_pwm_compare.sv
// tb_pwm_compare: scoreboard bench for pwm_compare with a cycle reference model.
module tb_pwm_compare;
  import pwm_pkg::*;
  localparam int DT = 4;
  logic clk = 0, rst = 1, en = 0, tcount = 0, pwm, period_done;
  logic [7:0] count = 0;
`ifdef PWM_COMPL_EN
  logic pwm_n;
`endif
  pwm_compare_if bus();
  pwm_compare #(.DEADTIME(DT)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .count       (count),
    .tcount      (tcount),
    .duty        (bus),
`ifdef PWM_COMPL_EN
    .pwm_n       (pwm_n),
`endif
    .pwm         (pwm),
    .period_done (period_done)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end
  typedef struct {int cyc; bit p; bit pn; bit pd; bit rdy;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  bit mon_on = 0;
  // reference model state
  int mode = 0;
  logic [7:0] act = 0, ctr = 0, req_d = 0;
  logic [7:0] dq[$];
  logic [15:0] hh = 0, hl = 0;
  bit en_s = 0, req_v = 0, rnd = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
    end
  endtask
  always @(negedge clk)
    if (mon_on && exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      chk("pwm", pwm, mon_e.p);
      chk("period_done", period_done, mon_e.pd);
      chk("duty_ready", bus.duty_ready, mon_e.rdy);
`ifdef PWM_COMPL_EN
      chk("pwm_n", pwm_n, mon_e.pn);
      chk("overlap", pwm & pwm_n, 0);
`endif
    end
  // One clock of stimulus; the model predicts the outputs after the next edge.
  task automatic step();
    bit xfer, raw, rawl, runm;
    exp_t ex;
    en = en_s;
    count = ctr;
    tcount = (ctr == 8'd255);
    bus.duty_valid = req_v;
    bus.duty_data = req_d;
    runm = (mode == 2) && en_s;
    raw = runm && (ctr < act);
    rawl = runm && !raw;
    xfer = req_v && dq.size() == 0;
    if (tcount && mode != 0 && dq.size() != 0) act = dq.pop_front();
    if (xfer) begin
      dq.push_back(req_d);
      req_v = 0;
    end
    mode = !en_s ? 0 : (mode == 0) ? 1 : (mode == 1 && tcount) ? 2 : mode;
    hh = {hh[14:0], raw};
    hl = {hl[14:0], rawl};
    ex.cyc = cyc + 1;
`ifdef PWM_COMPL_EN
    ex.p = &hh[DT:0];
    ex.pn = &hl[DT:0];
`else
    ex.p = raw;
    ex.pn = 0;
`endif
    ex.pd = runm && tcount;
    ex.rdy = dq.size() == 0;
    exp_q.push_back(ex);
    ctr = (rnd && $urandom_range(199) == 0) ? 8'($urandom) : ctr + 8'd1;
    @(posedge clk);
    #1;
  endtask
  task automatic run(int n);
    repeat (n) step();
  endtask
  task automatic send(logic [7:0] d);
    req_v = 1;
    req_d = d;
  endtask
  task automatic until_ctr(logic [7:0] v);
    while (ctr != v) step();
  endtask
  task automatic do_reset();
    rst = 0;
    #1;
    chk("rst_pwm", pwm, 0);
    chk("rst_period_done", period_done, 0);
    chk("rst_duty_ready", bus.duty_ready, 1);
`ifdef PWM_COMPL_EN
    chk("rst_pwm_n", pwm_n, 0);
`endif
    mon_on = 0;
    exp_q.delete();
    dq.delete();
    mode = 0;
    act = 0;
    hh = 0;
    hl = 0;
    req_v = 0;
    en_s = 0;
    en = 0;
    bus.duty_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    mon_on = 1;
    run(4);
  endtask
  initial begin
    bus.duty_valid = 0;
    bus.duty_data = 0;
    @(posedge clk);
    #1;
    do_reset();
    send(64);
    run(3);
    en_s = 1;
    run(3 * 256);
    until_ctr(100);
    send(200);
    run(600);
    until_ctr(20);
    send(30);
    run(5);
    send(90);
    run(600);
    send(0);
    run(600);
    send(255);
    run(600);
    until_ctr(255);
    send(5);
    run(600);
    send(3);
    run(600);
    send(100);
    run(300);
    until_ctr(30);
    en_s = 0;
    run(3);
    en_s = 1;
    run(600);
    send(128);
    run(300);
    until_ctr(60);
    do_reset();
    en_s = 1;
    run(300);
    rnd = 1;
    repeat (3000) begin
      if ($urandom_range(99) == 0) en_s = !en_s;
      if (!req_v && $urandom_range(29) == 0) send(8'($urandom));
      step();
    end
    rnd = 0;
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
